// File: rtl/img_stim_pkg.sv
// Shared types and constants for the raster stimulus source.
package img_stim_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_VS   = 3'd1,
    S_ACT  = 3'd2,
    S_HB   = 3'd3,
    S_VB   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Fibonacci LFSR: taps 10 and 7 -> feedback from bits 9 and 6.
  localparam logic [15:0] LFSR_SEED = 16'h0001;
  localparam logic [15:0] LFSR_TAPS = 16'h0240;

endpackage

// File: rtl/img_pattern_gen.sv
// Pixel pattern source: ramp (x+y) by default, LFSR when IMG_PATTERN_LFSR_EN is defined.
module img_pattern_gen
  import img_stim_pkg::*;
#(
  parameter int PIX_BITS = 10,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [XW-1:0]       x_i,
  input  logic [YW-1:0]       y_i,
  input  logic                advance_i,
  input  logic                reload_i,
  output logic [PIX_BITS-1:0] pix_o
);

`ifdef IMG_PATTERN_LFSR_EN
  logic [PIX_BITS-1:0] lfsr_q, lfsr_d;
  logic                fb;
  logic                unused_xy;

  assign unused_xy = ^{x_i, y_i};

  always_comb begin
    fb     = ^(lfsr_q & LFSR_TAPS[PIX_BITS-1:0]);
    lfsr_d = lfsr_q;
    if (reload_i) begin
      lfsr_d = LFSR_SEED[PIX_BITS-1:0];
    end else if (advance_i) begin
      lfsr_d = {lfsr_q[PIX_BITS-2:0], fb};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED[PIX_BITS-1:0];
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Current value is presented, then the register steps past it.
  assign pix_o = lfsr_q;
`else
  logic unused_ctl;

  assign unused_ctl = ^{clk_i, rst_i, advance_i, reload_i};
  assign pix_o      = PIX_BITS'(x_i) + PIX_BITS'(y_i);
`endif

endmodule

// File: rtl/source_image_stimul_gen.sv
// Raster video source: frames of IMG_WIDTH x IMG_HEIGHT, HSYNC as data-valid, VSYNC frame pulse.
// Optional LFSR pattern selected with macro IMG_PATTERN_LFSR_EN.
module source_image_stimul_gen
  import img_stim_pkg::*;
#(
  parameter int IMG_WIDTH   = 1024,
  parameter int IMG_HEIGHT  = 1024,
  parameter int H_BLANK     = 256,
  parameter int V_BLANK     = 1024,
  parameter int START_DELAY = 16,
  parameter int FRAMES      = 1,
  parameter int PIX_BITS    = 10
) (
  input  logic              PCLK,
  input  logic              RST,
  output logic [DATA_W-1:0] Pixel_DATA,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic [2:0]        dbg_state_o
);

  localparam int XW    = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int FR_W  = (FRAMES     > 1) ? $clog2(FRAMES + 1) : 1;
  localparam int MAX_A = (START_DELAY + 1 > H_BLANK) ? START_DELAY + 1 : H_BLANK;
  localparam int MAX_C = (MAX_A > V_BLANK) ? MAX_A : V_BLANK;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [XW-1:0]   X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]   Y_LAST  = YW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0]   D_LAST  = CW'(START_DELAY);
  localparam logic [CW-1:0]   H_LAST  = CW'(H_BLANK - 1);
  localparam logic [CW-1:0]   V_LAST  = CW'(V_BLANK - 1);
  localparam logic [FR_W-1:0] FR_LAST = (FRAMES == 0) ? '0 : FR_W'(FRAMES - 1);

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [FR_W-1:0]     frame_q, frame_d;
  logic [DATA_W-1:0]   pix_q;
  logic                hsync_q, vsync_q;
  logic [PIX_BITS-1:0] pattern;

  // One counter serves the start delay and both blanking intervals.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == D_LAST) begin
          state_d = S_VS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_VS: begin
        state_d = S_ACT;
        x_d     = '0;
        y_d     = '0;
        cnt_d   = '0;
      end
      S_ACT: begin
        if (x_q == X_LAST) begin
          state_d = S_HB;
          cnt_d   = '0;
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      S_HB: begin
        if (cnt_q == H_LAST) begin
          cnt_d = '0;
          x_d   = '0;
          if (y_q != Y_LAST) begin
            y_d     = y_q + YW'(1);
            state_d = S_ACT;
          end else begin
            y_d     = '0;
            state_d = S_VB;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_VB: begin
        if (cnt_q == V_LAST) begin
          cnt_d   = '0;
          frame_d = frame_q + FR_W'(1);
          if ((FRAMES == 0) || (frame_q != FR_LAST)) begin
            state_d = S_VS;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  img_pattern_gen #(
    .PIX_BITS(PIX_BITS),
    .XW      (XW),
    .YW      (YW)
  ) u_pattern (
    .clk_i    (PCLK),
    .rst_i    (RST),
    .x_i      (x_d),
    .y_i      (y_d),
    .advance_i(state_d == S_ACT),
    .reload_i (state_d == S_VS),
    .pix_o    (pattern)
  );

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge PCLK) begin
    if (RST) begin
      state_q <= S_WAIT;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      pix_q   <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      hsync_q <= (state_d == S_ACT);
      vsync_q <= (state_d == S_VS);
      pix_q   <= (state_d == S_ACT) ? DATA_W'(pattern) : '0;
    end
  end

  assign Pixel_DATA  = pix_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_source_image_stimul_gen.sv
// Directed bench for source_image_stimul_gen: one single-frame and one free-running instance.
module tb_source_image_stimul_gen;
  import img_stim_pkg::*;

  localparam int LEN = 200;

`ifdef IMG_PATTERN_LFSR_EN
  localparam logic [15:0] FIRST_PIX = 16'h0001;
`else
  localparam logic [15:0] FIRST_PIX = 16'h0000;
`endif

  logic        PCLK;
  logic        RST;
  logic [15:0] pd_o, pd_r_o;
  logic        hs_o, vs_o, hs_r_o, vs_r_o;
  logic [2:0]  st_o, st_r_o;

  logic        hs_a [LEN];
  logic        vs_a [LEN];
  logic [15:0] pd_a [LEN];
  logic        hs_r [LEN];
  logic        vs_r [LEN];
  logic [15:0] pd_r [LEN];

  int checks = 0;
  int errors = 0;

  source_image_stimul_gen #(
    .IMG_WIDTH(8), .IMG_HEIGHT(4), .H_BLANK(3), .V_BLANK(5),
    .START_DELAY(2), .FRAMES(1), .PIX_BITS(10)
  ) dut (
    .PCLK(PCLK), .RST(RST), .Pixel_DATA(pd_o), .HSYNC(hs_o), .VSYNC(vs_o),
    .dbg_state_o(st_o)
  );

  source_image_stimul_gen #(
    .IMG_WIDTH(8), .IMG_HEIGHT(4), .H_BLANK(3), .V_BLANK(5),
    .START_DELAY(2), .FRAMES(0), .PIX_BITS(10)
  ) dut_rep (
    .PCLK(PCLK), .RST(RST), .Pixel_DATA(pd_r_o), .HSYNC(hs_r_o), .VSYNC(vs_r_o),
    .dbg_state_o(st_r_o)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Cycle k is sampled on the negedge after the k-th edge with RST low.
  task automatic capture();
    RST = 1'b1;
    @(negedge PCLK);
    RST = 1'b0;
    for (int k = 0; k < LEN; k++) begin
      @(negedge PCLK);
      hs_a[k] = hs_o;   vs_a[k] = vs_o;   pd_a[k] = pd_o;
      hs_r[k] = hs_r_o; vs_r[k] = vs_r_o; pd_r[k] = pd_r_o;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge PCLK);
    checks++;
    if ({hs_o, vs_o, pd_o} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got hs=%b vs=%b pd=%h, want 0 0 0000", hs_o, vs_o, pd_o);
    end
    checks++;
    if (st_o !== 3'(S_WAIT)) begin
      errors++;
      $display("FAIL reset_state: got %0d, want %0d", st_o, S_WAIT);
    end
    checks++;
    if ({hs_r_o, vs_r_o, pd_r_o} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs_rep: got hs=%b vs=%b pd=%h, want 0", hs_r_o, vs_r_o, pd_r_o);
    end
  endtask

  task automatic test_sync_timing();
    int nvs = 0;
    int nhs = 0;
    for (int k = 0; k < LEN; k++) nvs += int'(vs_a[k]);
    for (int k = 3; k <= 10; k++) nhs += int'(hs_a[k]);
    checks++;
    if (vs_a[2] !== 1'b1 || nvs != 1) begin
      errors++;
      $display("FAIL vsync_first: got vs[2]=%b count=%0d, want 1 and 1", vs_a[2], nvs);
    end
    checks++;
    if (hs_a[2] !== 1'b0 || nhs != 8 || hs_a[11] !== 1'b0) begin
      errors++;
      $display("FAIL hsync_first_line: got hs[2]=%b run=%0d hs[11]=%b, want 0 8 0",
               hs_a[2], nhs, hs_a[11]);
    end
  endtask

  task automatic test_full_frame();
    int rises = 0;
    int valid = 0;
    int bad_pos = 0;
    for (int k = 0; k < LEN; k++) begin
      valid += int'(hs_a[k]);
      if (hs_a[k] && (k == 0 || !hs_a[k-1])) begin
        if (k != 3 + 11 * rises) bad_pos++;
        rises++;
      end
    end
    checks++;
    if (rises != 4 || bad_pos != 0) begin
      errors++;
      $display("FAIL hsync_rises: got %0d rises (%0d misplaced), want 4 at 3+11n", rises, bad_pos);
    end
    checks++;
    if (valid != 32) begin
      errors++;
      $display("FAIL valid_pixels: got %0d, want 32", valid);
    end
  endtask

  task automatic test_pixel_data();
    int idle_bad = 0;
    int hi_bad = 0;
`ifndef IMG_PATTERN_LFSR_EN
    logic [15:0] exp;
    for (int l = 0; l < 4; l += 3) begin
      for (int p = 0; p < 8; p++) begin
        exp = 16'(p + l);
        checks++;
        if (pd_a[3 + 11 * l + p] !== exp) begin
          errors++;
          $display("FAIL ramp_l%0d_p%0d: got %h, want %h", l, p, pd_a[3 + 11 * l + p], exp);
        end
      end
    end
`endif
    for (int k = 0; k < LEN; k++) begin
      if (!hs_a[k] && pd_a[k] !== 16'd0) idle_bad++;
      if (pd_a[k][15:10] !== 6'd0) hi_bad++;
    end
    checks++;
    if (idle_bad != 0) begin
      errors++;
      $display("FAIL idle_data_zero: got %0d nonzero idle cycles, want 0", idle_bad);
    end
    checks++;
    if (hi_bad != 0) begin
      errors++;
      $display("FAIL upper_bits_zero: got %0d cycles with bits[15:10]!=0, want 0", hi_bad);
    end
  endtask

  task automatic test_done();
    int bad = 0;
    for (int k = 44; k < LEN; k++) begin
      if (hs_a[k] !== 1'b0 || vs_a[k] !== 1'b0 || pd_a[k] !== 16'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL done_idle: got %0d active cycles after frame, want 0", bad);
    end
    checks++;
    if (st_o !== 3'(S_DONE)) begin
      errors++;
      $display("FAIL done_state: got %0d, want %0d", st_o, S_DONE);
    end
  endtask

  task automatic test_repeat();
    int nvs = 0;
    for (int k = 0; k <= 52; k++) nvs += int'(vs_r[k]);
    checks++;
    if (vs_r[52] !== 1'b1 || nvs != 2) begin
      errors++;
      $display("FAIL second_vsync: got vs[52]=%b count=%0d, want 1 and 2", vs_r[52], nvs);
    end
    checks++;
    if (hs_r[53] !== 1'b1 || pd_r[53] !== FIRST_PIX) begin
      errors++;
      $display("FAIL second_frame_start: got hs=%b pd=%h, want 1 %h", hs_r[53], pd_r[53], FIRST_PIX);
    end
  endtask

`ifdef IMG_PATTERN_LFSR_EN
  task automatic test_lfsr();
    int zeros = 0;
    int diff = 0;
    checks++;
    if (pd_r[3] !== 16'h0001 || pd_r[4] !== 16'h0002) begin
      errors++;
      $display("FAIL lfsr_first: got %h %h, want 0001 0002", pd_r[3], pd_r[4]);
    end
    for (int k = 0; k < LEN; k++) if (hs_r[k] && pd_r[k] == 16'd0) zeros++;
    for (int i = 0; i < 49; i++) begin
      if (hs_r[3 + i] !== hs_r[53 + i] || pd_r[3 + i] !== pd_r[53 + i]) diff++;
    end
    checks++;
    if (zeros != 0) begin
      errors++;
      $display("FAIL lfsr_nonzero: got %0d zero pixels, want 0", zeros);
    end
    checks++;
    if (diff != 0) begin
      errors++;
      $display("FAIL lfsr_repeat: got %0d differing cycles frame2 vs frame1, want 0", diff);
    end
  endtask
`endif

  task automatic test_mid_reset();
    int early_vs = 0;
    RST = 1'b1;
    @(negedge PCLK);
    RST = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge PCLK);
      if (k == 18) begin
        checks++;
`ifdef IMG_PATTERN_LFSR_EN
        if (hs_o !== 1'b1) begin
`else
        if (hs_o !== 1'b1 || pd_o !== 16'd5) begin
`endif
          errors++;
          $display("FAIL mid_line_pixel: got hs=%b pd=%h, want 1 0005", hs_o, pd_o);
        end
        RST = 1'b1;
      end else if (k == 19) begin
        checks++;
        if (hs_o !== 1'b0 || pd_o !== 16'd0 || vs_o !== 1'b0) begin
          errors++;
          $display("FAIL mid_reset_idle: got hs=%b vs=%b pd=%h, want 0 0 0000", hs_o, vs_o, pd_o);
        end
        RST = 1'b0;
      end else if (k == 20 || k == 21) begin
        early_vs += int'(vs_o);
      end else if (k == 22) begin
        checks++;
        if (vs_o !== 1'b1 || early_vs != 0) begin
          errors++;
          $display("FAIL restart_vsync: got vs=%b early=%0d, want 1 0", vs_o, early_vs);
        end
      end else if (k == 23) begin
        checks++;
        if (hs_o !== 1'b1 || pd_o !== FIRST_PIX) begin
          errors++;
          $display("FAIL restart_pixel0: got hs=%b pd=%h, want 1 %h", hs_o, pd_o, FIRST_PIX);
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    test_reset();
    capture();
    test_sync_timing();
    test_full_frame();
    test_pixel_data();
    test_done();
    test_repeat();
`ifdef IMG_PATTERN_LFSR_EN
    test_lfsr();
`endif
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/source_image_stimul_gen.md
Name: source_image_stimul_gen

Overview:
- Synthesizable raster video source that emits one or more frames of IMG_WIDTH x IMG_HEIGHT pixels, one pixel per PCLK.
- Drives the encoder's pixel input. HSYNC doubles as the per-line data-valid, and VSYNC marks the start of each frame.
- One RTL module covers the 1024-, 2048- and 4096-wide variants; the width is set by parameter.

Parameters:
- IMG_WIDTH, 1024, active pixels per line (1024/2048/4096 variants).
- IMG_HEIGHT, 1024, lines per frame.
- H_BLANK, 256, idle cycles after each line (>=1).
- V_BLANK, 1024, idle cycles after the last line's H_BLANK (>=1).
- START_DELAY, 16, idle cycles after reset release before the first frame (>=0).
- FRAMES, 1, frames to emit; 0 = repeat forever.
- PIX_BITS, 10, meaningful pixel bits (<=16).

Ports:
- PCLK  in  1  pixel clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- Pixel_DATA  out  16  pixel value; bits [15:PIX_BITS] are always 0.
- HSYNC  out  1  high during the active pixels of a line (the data-valid).
- VSYNC  out  1  one-cycle frame-start pulse.

Behaviour:
- Clocking and reset: one clock (PCLK); reset RST is synchronous and active-high.
- All outputs are registered.
- While RST=1 and in the cycle it is sampled: Pixel_DATA=0, HSYNC=0, VSYNC=0. State goes to S_WAIT, and all counters (x, y, frame, delay) clear.
- S_WAIT: count START_DELAY cycles, then go to S_VS.
- S_VS: VSYNC=1 for exactly one cycle, then go to S_ACT with x=0, y=0.
- S_ACT: HSYNC=1 for exactly IMG_WIDTH consecutive cycles. Pixel_DATA = pattern(x,y); x increments each cycle. When x=IMG_WIDTH-1, go to S_HB.
- S_HB: HSYNC=0 and Pixel_DATA=0 for H_BLANK cycles. Then:
  - if y<IMG_HEIGHT-1: y++, x=0, go to S_ACT;
  - otherwise go to S_VB.
- S_VB: outputs idle for V_BLANK cycles. frame++. Then:
  - if FRAMES=0 or frame<FRAMES: go to S_VS;
  - otherwise go to S_DONE.
- S_DONE: outputs idle permanently until RST.
- Pixel_DATA is 0 whenever HSYNC=0.
- HSYNC rises exactly IMG_HEIGHT times per frame; the first rise is the cycle after VSYNC.
- Default pattern (ramp): pattern(x,y) = (x + y) mod 2^PIX_BITS.
- Counter widths are $clog2 of their limits; x and y wrap to 0 at the frame boundary.
- RST asserted mid-line: outputs go idle on the next edge, and the generator restarts at S_WAIT (no partial-line continuation).
- START_DELAY=0: S_VS follows reset release immediately.

Optional Feature:
- Macro IMG_PATTERN_LFSR_EN.
- When defined: pattern = PIX_BITS-wide Fibonacci LFSR (10-bit taps 10,7; seed 10'h001).
  - The LFSR advances only on HSYNC=1 cycles.
  - It reloads the seed at each S_VS, so every frame is identical.
  - A value of 0 is never output.
- When undefined: the ramp pattern, with no LFSR logic present.

Decomposition:
- Shared package img_stim_pkg holds:
  - DATA_W=16;
  - the state enum {S_WAIT, S_VS, S_ACT, S_HB, S_VB, S_DONE};
  - LFSR seed and tap constants.
- One sub-module, img_pattern_gen:
  - inputs: x, y, advance, reload;
  - output: the PIX_BITS-bit value;
  - it contains the ramp/LFSR selection.
- The timing FSM and counters stay in the top.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=4, H_BLANK=3, V_BLANK=5, START_DELAY=2, FRAMES=1 unless stated):
- Reset, then release at cycle 0 -> VSYNC=1 at cycle 2 only; HSYNC first high at cycle 3 and stays high 8 cycles.
- Full frame -> exactly 4 HSYNC rising edges spaced 11 cycles apart; 32 valid pixels total.
- Ramp data -> line 0: 0..7; line 3: 3..10. Pixel_DATA=0 on every HSYNC=0 cycle, and bits [15:10]=0 always.
- End of frame -> after the last H_BLANK plus V_BLANK=5 cycles, all outputs stay 0 for 100+ cycles (S_DONE). With FRAMES=0, the second VSYNC pulse arrives exactly 4*11+5 cycles after the first line start.
- RST=1 for 1 cycle at pixel x=4 of line 1 -> HSYNC=0 the next cycle; the sequence restarts with VSYNC 2 cycles after release and line 0 pixel 0.
- IMG_PATTERN_LFSR_EN defined, FRAMES=2 -> the first pixel is 10'h001, no pixel equals 0, and frame 2 data is bit-identical to frame 1.
